// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI init sequencer: state encoding and width helpers.
package spi_seq_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_XFER  = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_ADC   = 3'd4;
   localparam logic [2:0] ST_FAULT = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      SETUP = ST_SETUP,
      XFER  = ST_XFER,
      HOLD  = ST_HOLD,
      ADC   = ST_ADC,
      FAULT = ST_FAULT
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int p = 1; p < v; p = p * 2) r++;
      return r;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable up-counter with a terminal flag; shared by the guard and timeout counts.
module spi_seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         en,
   input  logic [W-1:0] term_val,
   output logic         term
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) count <= '0;
      else if (en)      count <= count + W'(1);
   end

   assign term = (count == term_val);

endmodule

// File: rtl/spi_init_sequencer.sv
// Brings up N_DEV SPI peripherals in order (select guard, config transfer, deselect
// guard), retrying on timeout, then hands the bus to the ADC.
module spi_init_sequencer
   import spi_seq_pkg::*;
#(
   parameter  int N_DEV       = 2,
   parameter  int GUARD_CYC   = 4,
   parameter  int TIMEOUT_CYC = 1023,
   parameter  int MAX_RETRY   = 2,
   localparam int IW          = max2(1, clog2(N_DEV))
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic             abort,
   input  logic             init_done,
   output logic [N_DEV-1:0] cs_n,
   output logic             init,
   output logic [IW-1:0]    dev_idx,
   output logic             adc_sel,
   output logic             ready,
   output logic             error
);

   localparam int TW = max2(1, clog2(max2(GUARD_CYC, TIMEOUT_CYC)));
   localparam int RW = max2(1, clog2(MAX_RETRY + 1));

   state_t           state, nxt_state;
   logic [IW-1:0]    nxt_idx;
   logic [RW-1:0]    retry, nxt_retry;
   logic             retry_flag, nxt_flag;
   logic [N_DEV-1:0] nxt_cs_n;
   logic [TW-1:0]    term_val;
   logic             timer_term, timer_clear, timer_en;

   // One timer serves every timed state; it restarts from zero on each state change.
   assign term_val    = (state == XFER) ? TW'(TIMEOUT_CYC - 1) : TW'(GUARD_CYC - 1);
   assign timer_en    = state inside {SETUP, XFER, HOLD};
   assign timer_clear = (nxt_state != state);

   spi_seq_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (timer_clear),
      .en       (timer_en),
      .term_val (term_val),
      .term     (timer_term)
   );

   // Handshake: go is a level request honoured only in IDLE; init_done is a one-cycle
   // pulse from the shifter, accepted only while init is high (XFER), ignored elsewhere.
   always_comb begin
      nxt_state = state;
      nxt_idx   = dev_idx;
      nxt_retry = retry;
      nxt_flag  = retry_flag;
      if (abort) begin
         nxt_state = IDLE;
         nxt_idx   = '0;
         nxt_retry = '0;
         nxt_flag  = 1'b0;
      end else begin
         case (state)
            IDLE: if (go) begin
               nxt_state = SETUP;
               nxt_idx   = '0;
               nxt_retry = '0;
               nxt_flag  = 1'b0;
            end
            SETUP: if (timer_term) nxt_state = XFER;
            XFER: begin
               if (init_done) begin
                  nxt_state = HOLD;
                  nxt_flag  = 1'b0;
               end else if (timer_term) begin
                  if (retry < RW'(MAX_RETRY)) begin
                     nxt_state = HOLD;
                     nxt_flag  = 1'b1;
                     nxt_retry = retry + RW'(1);
                  end else begin
                     nxt_state = FAULT;
                  end
               end
            end
            HOLD: if (timer_term) begin
               if (retry_flag) begin
                  nxt_state = SETUP;
               end else if (dev_idx == IW'(N_DEV - 1)) begin
                  nxt_state = ADC;
               end else begin
                  nxt_state = SETUP;
                  nxt_idx   = dev_idx + IW'(1);
                  nxt_retry = '0;
               end
            end
            default: nxt_state = state;
         endcase
      end
   end

   always_comb begin
      nxt_cs_n = '1;
      for (int i = 0; i < N_DEV; i++)
         nxt_cs_n[i] = !((nxt_state inside {SETUP, XFER}) && (nxt_idx == IW'(i)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dev_idx    <= '0;
         retry      <= '0;
         retry_flag <= 1'b0;
         cs_n       <= '1;
         init       <= 1'b0;
         adc_sel    <= 1'b0;
         ready      <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= nxt_state;
         dev_idx    <= nxt_idx;
         retry      <= nxt_retry;
         retry_flag <= nxt_flag;
         cs_n       <= nxt_cs_n;
         init       <= (nxt_state == XFER);
         adc_sel    <= (nxt_state == ADC);
         ready      <= (nxt_state == ADC);
         error      <= (nxt_state == FAULT);
      end
   end

endmodule

// File: tb/tb_spi_init_sequencer.sv
// Directed bench for spi_init_sequencer: a 2-device build and a 1-device build.
module tb_spi_init_sequencer;

   logic       clk;
   logic       rst, go, abort, init_done;
   logic [1:0] cs_n;
   logic       init, adc_sel, ready, error;
   logic [0:0] dev_idx;

   logic       rst1, go1, abort1, init_done1;
   logic [0:0] cs_n1;
   logic       init1, adc_sel1, ready1, error1;
   logic [0:0] dev_idx1;

   int total = 0;
   int bad   = 0;
   logic [1:0] exp_q[$];

   spi_init_sequencer #(.N_DEV(2), .GUARD_CYC(4), .TIMEOUT_CYC(16), .MAX_RETRY(2)) dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort), .init_done(init_done),
      .cs_n(cs_n), .init(init), .dev_idx(dev_idx), .adc_sel(adc_sel),
      .ready(ready), .error(error)
   );

   spi_init_sequencer #(.N_DEV(1), .GUARD_CYC(4), .TIMEOUT_CYC(16), .MAX_RETRY(2)) dut1 (
      .clk(clk), .rst(rst1), .go(go1), .abort(abort1), .init_done(init_done1),
      .cs_n(cs_n1), .init(init1), .dev_idx(dev_idx1), .adc_sel(adc_sel1),
      .ready(ready1), .error(error1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int         init_cycles;
      int         windows;
      int         dev1_seen;
      logic       prev;
      logic [1:0] e;

      rst = 1'b1; go = 1'b0; abort = 1'b0; init_done = 1'b0;
      rst1 = 1'b1; go1 = 1'b0; abort1 = 1'b0; init_done1 = 1'b0;
      step(); step();
      chk("rst_cs_n",    32'(cs_n),    32'h3);
      chk("rst_init",    32'(init),    32'h0);
      chk("rst_dev_idx", 32'(dev_idx), 32'h0);
      chk("rst_adc_sel", 32'(adc_sel), 32'h0);
      chk("rst_ready",   32'(ready),   32'h0);
      chk("rst_error",   32'(error),   32'h0);
      rst = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      chk("idle_cs_n", 32'(cs_n), 32'h3);

      // nominal: init_done in cycles 7 and 18
      for (int c = 1; c <= 23; c++)
         exp_q.push_back((c <= 7) ? 2'b10 : (c <= 11) ? 2'b11 : (c <= 18) ? 2'b01 : 2'b11);
      go = 1'b1; step(); go = 1'b0;
      for (int c = 1; c <= 23; c++) begin
         init_done = (c == 7 || c == 18);
         e = exp_q.pop_front();
         chk($sformatf("nom_cs_n_c%0d", c), 32'(cs_n), 32'(e));
         chk($sformatf("nom_init_c%0d", c), 32'(init),
             32'((c >= 5 && c <= 7) || (c >= 16 && c <= 18)));
         chk($sformatf("nom_ready_c%0d", c), 32'(ready), 32'(c >= 23));
         chk($sformatf("nom_idx_c%0d", c), 32'(dev_idx), 32'(c >= 12));
         step();
         init_done = 1'b0;
      end
      go = 1'b1; step(); step(); go = 1'b0;
      chk("adc_hold_ready",   32'(ready),   32'h1);
      chk("adc_hold_adc_sel", 32'(adc_sel), 32'h1);
      chk("adc_hold_cs_n",    32'(cs_n),    32'h3);
      abort = 1'b1; step(); abort = 1'b0;
      chk("adc_abort_ready", 32'(ready),   32'h0);
      chk("adc_abort_sel",   32'(adc_sel), 32'h0);
      chk("adc_abort_cs_n",  32'(cs_n),    32'h3);

      // retry: dev0 never answers -> three 16-cycle XFER windows then FAULT
      go = 1'b1; step(); go = 1'b0;
      init_cycles = 0; windows = 0; dev1_seen = 0; prev = 1'b0;
      for (int c = 1; c <= 68; c++) begin
         if (init) init_cycles++;
         if (init && !prev) windows++;
         prev = init;
         if (cs_n == 2'b01 || cs_n == 2'b00) dev1_seen++;
         if (c == 68) chk("retry_err_before", 32'(error), 32'h0);
         step();
      end
      chk("retry_init_cycles", 32'(init_cycles), 32'd48);
      chk("retry_windows",     32'(windows),     32'd3);
      chk("retry_dev1_seen",   32'(dev1_seen),   32'd0);
      chk("fault_error",       32'(error),       32'h1);
      chk("fault_cs_n",        32'(cs_n),        32'h3);
      chk("fault_ready",       32'(ready),       32'h0);
      chk("fault_init",        32'(init),        32'h0);
      go = 1'b1; step(); step(); go = 1'b0;
      chk("fault_sticky", 32'(error), 32'h1);
      abort = 1'b1; step(); abort = 1'b0;
      chk("fault_abort_error", 32'(error), 32'h0);

      // simultaneous init_done/timeout on the 16th XFER cycle; stray pulses ignored
      go = 1'b1; step(); go = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         init_done = (c == 2 || c == 20 || c == 22);
         if (c == 5)  chk("sim_xfer_start", 32'(init), 32'h1);
         if (c == 20) chk("sim_xfer_last",  32'(init), 32'h1);
         if (c == 21) chk("sim_hold_cs_n",  32'(cs_n), 32'h3);
         step();
         init_done = 1'b0;
      end
      chk("sim_dev_idx", 32'(dev_idx), 32'h1);
      chk("sim_cs_n",    32'(cs_n),    32'h1);
      chk("sim_error",   32'(error),   32'h0);
      chk("sim_init",    32'(init),    32'h0);

      // abort in the 3rd XFER cycle of dev1 (cycle 31)
      repeat (6) step();
      chk("abort_pre_init", 32'(init), 32'h1);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_cs_n",  32'(cs_n),  32'h3);
      chk("abort_init",  32'(init),  32'h0);
      chk("abort_ready", 32'(ready), 32'h0);
      go = 1'b1; step(); go = 1'b0;
      chk("restart_dev_idx", 32'(dev_idx), 32'h0);
      chk("restart_cs_n",    32'(cs_n),    32'h2);

      // reset mid-XFER with go and abort held high
      repeat (5) step();
      chk("mid_xfer_init", 32'(init), 32'h1);
      rst = 1'b1; go = 1'b1; abort = 1'b1; step();
      chk("mrst_cs_n",    32'(cs_n),    32'h3);
      chk("mrst_init",    32'(init),    32'h0);
      chk("mrst_dev_idx", 32'(dev_idx), 32'h0);
      chk("mrst_adc_sel", 32'(adc_sel), 32'h0);
      chk("mrst_ready",   32'(ready),   32'h0);
      chk("mrst_error",   32'(error),   32'h0);
      rst = 1'b0; abort = 1'b0; step(); go = 1'b0;
      chk("post_rst_cs_n", 32'(cs_n), 32'h2);
      chk("post_rst_init", 32'(init), 32'h0);

      // single-device build
      rst1 = 1'b0; go1 = 1'b1; step(); go1 = 1'b0;
      chk("n1_cs_n",    32'(cs_n1),    32'h0);
      chk("n1_dev_idx", 32'(dev_idx1), 32'h0);
      for (int c = 1; c <= 10; c++) begin
         init_done1 = (c == 6);
         if (c == 10) chk("n1_ready_hold", 32'(ready1), 32'h0);
         step();
         init_done1 = 1'b0;
      end
      chk("n1_ready",   32'(ready1),   32'h1);
      chk("n1_adc_sel", 32'(adc_sel1), 32'h1);
      chk("n1_cs_n_adc", 32'(cs_n1),   32'h1);
      chk("n1_error",   32'(error1),   32'h0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
